// File: rtl/des_sbox_scheduler.sv
// des_sbox_scheduler: time-multiplexes one shared DES S-box lookup across S1..S8 (one lookup per cycle)
// and assembles the 32-bit pre-permutation word. Optional macro DES_SBOX_SCHED_STATS_EN adds blocks_done/busy.
module des_sbox_scheduler #(
    parameter int unsigned SBOX_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef DES_SBOX_SCHED_STATS_EN
    ,
    output logic [15:0] blocks_done,
    output logic        busy
`endif
);

    localparam int unsigned DATA_W  = 48;
    localparam int unsigned CHUNK_W = 6;
    localparam int unsigned RES_W   = 4;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(7 + SBOX_LAT);

    if (SBOX_LAT > 1) begin : g_bad_lat
        $error("des_sbox_scheduler: SBOX_LAT must be 0 or 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_hold;
    logic [SEL_W-1:0]   r_sel;
    logic [CHUNK_W-1:0] r_sin;
    logic [OUT_W-1:0]   r_out;
    logic               r_in_ready;
    logic               r_out_valid;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  w_hold_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [CHUNK_W-1:0] w_sin_nxt;
    logic [OUT_W-1:0]   w_out_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;

    // Holding register shifts left one chunk per issue so the next address is always at the top.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold;
        w_sel_nxt       = r_sel;
        w_sin_nxt       = r_sin;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = {in_data[DATA_W-CHUNK_W-1:0], CHUNK_W'(0)};
                    w_sel_nxt   = '0;
                    w_sin_nxt   = in_data[DATA_W-1 -: CHUNK_W];
                    w_out_nxt   = '0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // The first SBOX_LAT cycles of RUN have no returned result yet.
                if ((SBOX_LAT == 0) || (r_cnt != '0)) begin
                    w_out_nxt = {r_out[OUT_W-RES_W-1:0], sbox_out};
                end
                if (r_cnt < LAST_ISSUE) begin
                    w_sel_nxt  = r_sel + SEL_W'(1);
                    w_sin_nxt  = r_hold[DATA_W-1 -: CHUNK_W];
                    w_hold_nxt = {r_hold[DATA_W-CHUNK_W-1:0], CHUNK_W'(0)};
                end
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_sel       <= '0;
            r_sin       <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_sel       <= w_sel_nxt;
            r_sin       <= w_sin_nxt;
            r_out       <= w_out_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign sbox_sel  = r_sel;
    assign sbox_in   = r_sin;

`ifdef DES_SBOX_SCHED_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] r_blocks;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blocks <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_blocks <= r_blocks + STAT_W'(1);
            end
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    assign blocks_done = r_blocks;
    assign busy        = r_busy;
`endif

endmodule
